// File: rtl/chimera_eoc_pkg.sv
// Shared definitions for the Chimera end-of-computation unit:
// register offsets, FSM states and the watchdog exit code.
package chimera_eoc_pkg;

  localparam logic [3:0] EocOffset       = 4'h0;
  localparam logic [3:0] StatusOffset    = 4'h4;
  localparam logic [3:0] WdogLimitOffset = 4'h8;
  localparam logic [3:0] WdogCountOffset = 4'hC;

  localparam logic [30:0] WdogExitCode = 31'h7FFF_FFFF;

  typedef enum logic {
    EocRun,
    EocDone
  } eoc_state_e;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/chimera_eoc_wdog.sv
// Cycle watchdog: programmable limit, saturating counter and a
// one-cycle expiry request while the run is still active.
module chimera_eoc_wdog
  import chimera_eoc_pkg::*;
#(
  parameter logic [31:0] ResetLimit = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        limit_we_i,
  input  logic [31:0] limit_wdata_i,
  input  logic [3:0]  limit_wstrb_i,
  output logic [31:0] limit_o,
  output logic [31:0] count_o,
  output logic        expire_o
);

  logic [31:0] limit_d, limit_q;
  logic [31:0] count_d, count_q;
  logic [32:0] count_inc;
  logic        armed;

  always_comb begin
    count_inc = {1'b0, count_q} + 33'd1;
    armed     = run_i && (limit_q != '0);
    // A limit write in the same cycle suppresses expiry
    expire_o  = armed && !limit_we_i &&
                (count_inc == {1'b0, limit_q});
    limit_d   = limit_q;
    count_d   = count_q;
    if (limit_we_i) begin
      limit_d = strb_merge(limit_q, limit_wdata_i,
                           limit_wstrb_i);
      count_d = '0;
    end else if (armed && !expire_o && !count_inc[32]) begin
      count_d = count_inc[31:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      limit_q <= ResetLimit;
      count_q <= '0;
    end else begin
      limit_q <= limit_d;
      count_q <= count_d;
    end
  end

  assign limit_o = limit_q;
  assign count_o = count_q;

endmodule

// File: rtl/chimera_eoc_unit.sv
// EOC / exit-code register block with watchdog and cluster tracking.
// Optional: CHIMERA_EOC_CLUSTER_AGG_EN ends the run when all clusters are done.
module chimera_eoc_unit
  import chimera_eoc_pkg::*;
#(
  parameter int unsigned NumClusters    = 5,
  parameter int unsigned DataWidth      = 32,
  parameter logic [31:0] WdogResetLimit = 32'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reg_req_valid_i,
  output logic                   reg_req_ready_o,
  input  logic                   reg_req_write_i,
  input  logic [3:0]             reg_req_addr_i,
  input  logic [DataWidth-1:0]   reg_req_wdata_i,
  input  logic [3:0]             reg_req_wstrb_i,
  output logic                   reg_rsp_valid_o,
  input  logic                   reg_rsp_ready_i,
  output logic [DataWidth-1:0]   reg_rsp_rdata_o,
  output logic                   reg_rsp_error_o,
  input  logic [NumClusters-1:0] cluster_done_i,
  output logic                   eoc_o,
  output logic [30:0]            exit_code_o,
  output logic                   wdog_expired_o
);

  eoc_state_e state_d, state_q;
  logic [30:0] exit_d, exit_q;
  logic        wdog_d, wdog_q;
  logic [NumClusters-1:0] sticky_d, sticky_q;
  logic        rsp_valid_d, rsp_valid_q;
  logic        rsp_error_d, rsp_error_q;
  logic [31:0] rsp_rdata_d, rsp_rdata_q;

  logic        req_hs, eoc_we, sw_eoc, limit_we, expire;
  logic [31:0] limit, count, status;

  assign reg_req_ready_o = !rsp_valid_q;
  assign req_hs = reg_req_valid_i && reg_req_ready_o;
  assign status = {{(30-NumClusters){1'b0}}, sticky_q,
                   wdog_q, (state_q == EocDone)};
  assign sticky_d = sticky_q | cluster_done_i;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    eoc_we      = 1'b0;
    limit_we    = 1'b0;
    if (rsp_valid_q && reg_rsp_ready_i) rsp_valid_d = 1'b0;
    if (req_hs) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
      unique case (1'b1)
        reg_req_addr_i == EocOffset: begin
          if (!reg_req_write_i)
            rsp_rdata_d = {exit_q, (state_q == EocDone)};
          else if (reg_req_wstrb_i != 4'hF)
            rsp_error_d = 1'b1;
          else
            eoc_we = 1'b1;
        end
        reg_req_addr_i == StatusOffset: begin
          if (reg_req_write_i) rsp_error_d = 1'b1;
          else rsp_rdata_d = status;
        end
        reg_req_addr_i == WdogLimitOffset: begin
          if (reg_req_write_i) limit_we = 1'b1;
          else rsp_rdata_d = limit;
        end
        reg_req_addr_i == WdogCountOffset: begin
          if (reg_req_write_i) rsp_error_d = 1'b1;
          else rsp_rdata_d = count;
        end
        default: rsp_error_d = 1'b1;
      endcase
    end
  end

  assign sw_eoc = eoc_we && reg_req_wdata_i[0];

  chimera_eoc_wdog #(
    .ResetLimit(WdogResetLimit)
  ) i_wdog (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .run_i        (state_q == EocRun),
    .limit_we_i   (limit_we && (state_q == EocRun)),
    .limit_wdata_i(reg_req_wdata_i),
    .limit_wstrb_i(reg_req_wstrb_i),
    .limit_o      (limit),
    .count_o      (count),
    .expire_o     (expire)
  );

  always_comb begin
    state_d = state_q;
    exit_d  = exit_q;
    wdog_d  = wdog_q;
    if (state_q == EocRun) begin
      if (sw_eoc) begin
        state_d = EocDone;
        exit_d  = reg_req_wdata_i[31:1];
      end else if (expire) begin
        state_d = EocDone;
        exit_d  = WdogExitCode;
        wdog_d  = 1'b1;
`ifdef CHIMERA_EOC_CLUSTER_AGG_EN
      end else if (!eoc_we && (&sticky_q)) begin
        state_d = EocDone;
        exit_d  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= EocRun;
      exit_q      <= '0;
      wdog_q      <= 1'b0;
      sticky_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exit_q      <= exit_d;
      wdog_q      <= wdog_d;
      sticky_q    <= sticky_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_comb begin
    eoc_o           = (state_q == EocDone);
    exit_code_o     = exit_q;
    wdog_expired_o  = wdog_q;
    reg_rsp_valid_o = rsp_valid_q;
    reg_rsp_rdata_o = rsp_rdata_q;
    reg_rsp_error_o = rsp_error_q;
  end

endmodule
